stfq_rank_compute: RTL and testbench
====================================

STFQ_RANK_COMPUTE -- requirements
Module: stfq_rank_compute

Interface
REQ-001 Parameter FLOWS, default 10, number of flows.
REQ-002 Parameter SIZE, default 50, per-flow slot count of the downstream rank store.
REQ-003 Parameter FW, default $clog2(FLOWS), flow-index width.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 in_valid  in  1  packet descriptor offered.
REQ-007 in_ready  out  1  descriptor accepted when in_valid && in_ready.
REQ-008 in_flow  in  FW  binary flow index.
REQ-009 in_len  in  16  packet length in bytes.
REQ-010 in_value  in  32  opaque payload/handle.
REQ-011 cfg_we, cfg_flow[FW], cfg_shift[4]  in  weight write: flow cfg_flow gets shift cfg_shift.
REQ-012 vt_update  in  1; vt_rank  in  32: start tag of the packet entering service.
REQ-013 pop  in  1; pop_flow  in  FLOWS one-hot: mirror of dequeue issued to the rank store.
REQ-014 push  out  1; push_rank  out  32; push_value  out  32; push_flow  out  FLOWS one-hot: enqueue to the rank store.
REQ-015 err  out  1  sticky underflow/illegal-index flag.

Function
REQ-016 Per flow, hold last_finish[32], shift[4], count[$clog2(SIZE+1)]; globally, vt[32].
REQ-017 in_ready SHALL be combinational: high iff in_flow < FLOWS, count[in_flow] < SIZE, and not rst.
REQ-018 On accept: start = max(vt, last_finish[in_flow]) (unsigned); finish = start + ({16'b0,in_len} << shift[in_flow]), truncated mod 2^32.
REQ-019 On accept, last_finish[in_flow] <= finish at the same edge; back-to-back same-flow accepts SHALL see the updated value with no bubble.
REQ-020 Latency 1: cycle after accept, push=1, push_rank=start, push_value=in_value, push_flow=1<<in_flow; otherwise push=0 and other outputs hold.
REQ-021 Throughput one descriptor per cycle; push is fire-and-forget (downstream has no ready).
REQ-022 count[f] increments on accept to f, decrements on pop with pop_flow[f]; both in one cycle to the same f leaves it unchanged.
REQ-023 Pop on a flow with count 0: count stays 0, err <= 1.
REQ-024 pop_flow not one-hot while pop=1: no count change, err <= 1.
REQ-025 vt_update: vt <= vt_rank only if vt_rank > vt (monotone); an accept in the same cycle uses the old vt.
REQ-026 cfg_we: shift[cfg_flow] updated at edge; an accept to the same flow in the same cycle uses the old shift; cfg_flow >= FLOWS ignored.
REQ-027 Tag wrap-around beyond 2^32 is not handled; comparison is plain unsigned.

Reset
REQ-028 On rst: push=0, push_rank=0, push_value=0, push_flow=0, err=0, vt=0, all last_finish=0, shift=0, count=0.
REQ-029 rst mid-operation discards any pending push; no push asserts in the cycle after rst.

Structure
REQ-030 Shared package holds rank_t (32-bit), value_t (32-bit), and default FLOWS/SIZE constants used with the rank store.
REQ-031 Per-flow occupancy counter bank is one sub-module, flow_credit_counter, owning count, full, and underflow detection.

Verification
REQ-032 Reset, shift[0]=0, accept flow 0 len 100 then len 50 -> push_rank 0 then 100; last_finish[0]=150.
REQ-033 shift[2]=2, vt_update vt_rank=1000, accept flow 2 len 10 -> push_rank 1000, push_flow=4'b0100 (low bits), last_finish[2]=1040.
REQ-034 SIZE=4, five accepts to flow 1 with no pops -> in_ready low on fifth; pop flow 1 same cycle as retry -> accepted next cycle, count stays 4.
REQ-035 Pop flow 3 with count 0 -> err=1 sticky, count 0; then vt_update 5 after vt=9 -> vt stays 9.
REQ-036 cfg_we shift[0]=1 same cycle as accept flow 0 len 8 (old shift 0) -> finish advances by 8; next len 8 advances by 16.
REQ-037 Assert rst the cycle after an accept -> no push observed; all state zero.

Source files
------------

// File: rtl/stfq_rank_compute_pkg.sv
// Shared types and constants for the STFQ rank computation block and the
// downstream rank store it feeds.
//   rank_t / value_t : 32-bit start tag and opaque payload handle
//   DEFAULT_FLOWS    : number of flows served by the rank store
//   DEFAULT_SIZE     : per-flow slot count of the rank store
//   scaled_len()     : packet length weighted by a per-flow shift
package stfq_rank_compute_pkg;

    typedef logic [31:0] rank_t;
    typedef logic [31:0] value_t;

    localparam int DEFAULT_FLOWS = 10;
    localparam int DEFAULT_SIZE  = 50;
    localparam int LEN_W         = 16;
    localparam int SHIFT_W       = 4;

    // Zero-extend before shifting so no weighted bits fall off the top of the
    // 16-bit length; the result wraps modulo 2^32 like every tag.
    function automatic rank_t scaled_len(input logic [LEN_W-1:0] len,
                                         input logic [SHIFT_W-1:0] sh);
        return rank_t'(len) << sh;
    endfunction

endpackage

// File: rtl/stfq_rank_compute_flow_credit_counter.sv
// Per-flow occupancy counters mirroring the rank store.
//   clk, rst       : clock, synchronous active-high reset
//   inc_i          : a descriptor was accepted for flow inc_flow_i
//   pop_i          : a dequeue was issued for the one-hot flow pop_flow_i
//   full_o         : per-flow, occupancy has reached SIZE
//   err_o          : single-cycle pulse on underflow or non-one-hot pop
module flow_credit_counter
    import stfq_rank_compute_pkg::*;
#(
    parameter int FLOWS = DEFAULT_FLOWS,
    parameter int SIZE  = DEFAULT_SIZE,
    parameter int FW    = $clog2(FLOWS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic [FW-1:0]    inc_flow_i,
    input  logic             pop_i,
    input  logic [FLOWS-1:0] pop_flow_i,
    output logic [FLOWS-1:0] full_o,
    output logic             err_o
);

    localparam int CW = $clog2(SIZE + 1);

    logic [CW-1:0]    count_q [FLOWS];
    logic [CW-1:0]    count_d [FLOWS];
    logic             pop_legal;
    logic [FLOWS-1:0] inc_hit;
    logic [FLOWS-1:0] dec_hit;
    logic [FLOWS-1:0] underflow;

    always_comb begin
        pop_legal = pop_i && $onehot(pop_flow_i);
        inc_hit   = '0;
        dec_hit   = '0;
        underflow = '0;
        for (int f = 0; f < FLOWS; f++) begin
            count_d[f] = count_q[f];
            full_o[f]  = (count_q[f] == CW'(SIZE));
            inc_hit[f] = inc_i && (inc_flow_i == FW'(f));
            // A pop against an empty flow is flagged and never decrements.
            underflow[f] = pop_legal && pop_flow_i[f] && (count_q[f] == '0);
            dec_hit[f]   = pop_legal && pop_flow_i[f] && (count_q[f] != '0);
            if (inc_hit[f] && !dec_hit[f]) begin
                count_d[f] = count_q[f] + CW'(1);
            end else if (dec_hit[f] && !inc_hit[f]) begin
                count_d[f] = count_q[f] - CW'(1);
            end
        end
        err_o = (pop_i && !$onehot(pop_flow_i)) || (|underflow);
    end

    always_ff @(posedge clk) begin
        for (int f = 0; f < FLOWS; f++) begin
            if (rst) begin
                count_q[f] <= '0;
            end else begin
                count_q[f] <= count_d[f];
            end
        end
    end

endmodule

// File: rtl/stfq_rank_compute.sv
// Start-time fair queueing rank computation. Each accepted descriptor gets
// start = max(vt, last_finish[flow]); the flow's finish tag advances by the
// shift-weighted length. The start tag is pushed to the rank store one cycle
// after acceptance.
//   clk, rst                     : clock, synchronous active-high reset
//   in_valid/in_ready/in_flow/in_len/in_value : descriptor handshake
//   cfg_we/cfg_flow/cfg_shift    : per-flow weight (shift) write
//   vt_update/vt_rank            : monotone virtual-time advance
//   pop/pop_flow                 : mirror of rank-store dequeues (one-hot)
//   push/push_rank/push_value/push_flow : enqueue to the rank store
//   err                          : sticky underflow / illegal pop flag
module stfq_rank_compute
    import stfq_rank_compute_pkg::*;
#(
    parameter int FLOWS = DEFAULT_FLOWS,
    parameter int SIZE  = DEFAULT_SIZE,
    parameter int FW    = $clog2(FLOWS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [FW-1:0]      in_flow,
    input  logic [LEN_W-1:0]   in_len,
    input  value_t             in_value,
    input  logic               cfg_we,
    input  logic [FW-1:0]      cfg_flow,
    input  logic [SHIFT_W-1:0] cfg_shift,
    input  logic               vt_update,
    input  rank_t              vt_rank,
    input  logic               pop,
    input  logic [FLOWS-1:0]   pop_flow,
    output logic               push,
    output rank_t              push_rank,
    output value_t             push_value,
    output logic [FLOWS-1:0]   push_flow,
    output logic               err
);

    rank_t              last_finish_q [FLOWS];
    logic [SHIFT_W-1:0] shift_q [FLOWS];
    rank_t              vt_q;
    logic               push_q;
    rank_t              push_rank_q;
    value_t             push_value_q;
    logic [FLOWS-1:0]   push_flow_q;
    logic               err_q;

    logic [FLOWS-1:0]   full;
    logic [FLOWS-1:0]   flow_sel;
    logic               flow_ok;
    logic               accept;
    logic               cnt_err;
    rank_t              cur_finish;
    logic [SHIFT_W-1:0] cur_shift;
    rank_t              start_d;
    rank_t              finish_d;

    // Flow lookup by compare rather than direct indexing, so an out-of-range
    // in_flow selects nothing and simply leaves in_ready low.
    always_comb begin
        flow_sel   = '0;
        flow_ok    = 1'b0;
        cur_finish = '0;
        cur_shift  = '0;
        for (int f = 0; f < FLOWS; f++) begin
            if (in_flow == FW'(f)) begin
                flow_sel[f] = 1'b1;
                flow_ok     = !full[f];
                cur_finish  = last_finish_q[f];
                cur_shift   = shift_q[f];
            end
        end
        in_ready = flow_ok && !rst;
        accept   = in_valid && in_ready;
        start_d  = (vt_q > cur_finish) ? vt_q : cur_finish;
        finish_d = start_d + scaled_len(in_len, cur_shift);
    end

    flow_credit_counter #(
        .FLOWS (FLOWS),
        .SIZE  (SIZE),
        .FW    (FW)
    ) u_credit (
        .clk        (clk),
        .rst        (rst),
        .inc_i      (accept),
        .inc_flow_i (in_flow),
        .pop_i      (pop),
        .pop_flow_i (pop_flow),
        .full_o     (full),
        .err_o      (cnt_err)
    );

    // Updates to shift and vt land at the edge, so a same-cycle accept still
    // sees the old values through the combinational path above.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int f = 0; f < FLOWS; f++) begin
                last_finish_q[f] <= '0;
                shift_q[f]       <= '0;
            end
            vt_q         <= '0;
            push_q       <= 1'b0;
            push_rank_q  <= '0;
            push_value_q <= '0;
            push_flow_q  <= '0;
            err_q        <= 1'b0;
        end else begin
            push_q <= accept;
            if (accept) begin
                push_rank_q  <= start_d;
                push_value_q <= in_value;
                push_flow_q  <= flow_sel;
            end
            for (int f = 0; f < FLOWS; f++) begin
                if (accept && flow_sel[f]) begin
                    last_finish_q[f] <= finish_d;
                end
                if (cfg_we && (cfg_flow == FW'(f))) begin
                    shift_q[f] <= cfg_shift;
                end
            end
            if (vt_update && (vt_rank > vt_q)) begin
                vt_q <= vt_rank;
            end
            if (cnt_err) begin
                err_q <= 1'b1;
            end
        end
    end

    assign push       = push_q;
    assign push_rank  = push_rank_q;
    assign push_value = push_value_q;
    assign push_flow  = push_flow_q;
    assign err        = err_q;

endmodule

// File: tb/tb_stfq_rank_compute.sv
module tb_stfq_rank_compute;
    import stfq_rank_compute_pkg::*;

    localparam int FLOWS = 10;
    localparam int SIZE  = 4;
    localparam int FW    = $clog2(FLOWS);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [FW-1:0]    in_flow = '0;
    logic [15:0]      in_len = '0;
    value_t           in_value = '0;
    logic             cfg_we = 1'b0;
    logic [FW-1:0]    cfg_flow = '0;
    logic [3:0]       cfg_shift = '0;
    logic             vt_update = 1'b0;
    rank_t            vt_rank = '0;
    logic             pop = 1'b0;
    logic [FLOWS-1:0] pop_flow = '0;
    logic             push;
    rank_t            push_rank;
    value_t           push_value;
    logic [FLOWS-1:0] push_flow;
    logic             err;

    stfq_rank_compute #(.FLOWS(FLOWS), .SIZE(SIZE), .FW(FW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_flow(in_flow),
        .in_len(in_len), .in_value(in_value),
        .cfg_we(cfg_we), .cfg_flow(cfg_flow), .cfg_shift(cfg_shift),
        .vt_update(vt_update), .vt_rank(vt_rank),
        .pop(pop), .pop_flow(pop_flow),
        .push(push), .push_rank(push_rank), .push_value(push_value),
        .push_flow(push_flow), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               due;
        rank_t            rank;
        value_t           val;
        logic [FLOWS-1:0] flow;
    } exp_t;

    typedef struct {
        int          flow;
        int          len;
        logic [31:0] val;
        bit          rdy;
        logic [31:0] rank;
    } vec_t;

    exp_t sb[$];
    exp_t last_exp;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard consumer: each expected push must appear exactly on its due cycle;
    // between pushes the payload outputs must hold the last pushed values.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst) begin
            while (sb.size() > 0 && sb[0].due < cyc) begin
                e = sb.pop_front();
                chk("push_missing", 32'(cyc), 32'(e.due));
            end
            if (push) begin
                if (sb.size() == 0 || sb[0].due != cyc) begin
                    chk("push_unexpected", 32'(push), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("push_rank", push_rank, e.rank);
                    chk("push_value", push_value, e.val);
                    chk("push_flow", 32'(push_flow), 32'(e.flow));
                    last_exp = e;
                end
            end else begin
                chk("hold_rank", push_rank, last_exp.rank);
                chk("hold_value", push_value, last_exp.val);
                chk("hold_flow", 32'(push_flow), 32'(last_exp.flow));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0; cfg_we = 1'b0; vt_update = 1'b0; pop = 1'b0; pop_flow = '0;
        sb.delete();
        last_exp = '{due: 0, rank: '0, val: '0, flow: '0};
        tick();
        tick();
        rst = 1'b0;
        chk("rst_push", 32'(push), 32'd0);
        chk("rst_push_rank", push_rank, 32'd0);
        chk("rst_push_value", push_value, 32'd0);
        chk("rst_push_flow", 32'(push_flow), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
    endtask

    task automatic send(input int flow, input int len, input logic [31:0] val,
                        input bit exp_rdy, input logic [31:0] exp_rank);
        exp_t e;
        logic [FLOWS-1:0] oh;
        in_valid = 1'b1;
        in_flow  = FW'(flow);
        in_len   = 16'(len);
        in_value = val;
        #1;
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        if (exp_rdy) begin
            oh = '0;
            oh[flow] = 1'b1;
            e = '{due: cyc + 1, rank: exp_rank, val: val, flow: oh};
            sb.push_back(e);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pop_on(input int flow);
        pop = 1'b1;
        pop_flow = '0;
        pop_flow[flow] = 1'b1;
    endtask

    task automatic pop_off();
        pop = 1'b0;
        pop_flow = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t tbl[8];

    initial begin
        tbl[0] = '{0, 100,   32'hA0, 1, 32'd0};
        tbl[1] = '{0, 50,    32'hA1, 1, 32'd100};
        tbl[2] = '{5, 7,     32'hA2, 1, 32'd0};
        tbl[3] = '{12, 1,    32'hA3, 0, 32'd0};
        tbl[4] = '{0, 1,     32'hA4, 1, 32'd150};
        tbl[5] = '{5, 3,     32'hA5, 1, 32'd7};
        tbl[6] = '{9, 65535, 32'hA6, 1, 32'd0};
        tbl[7] = '{9, 1,     32'hA7, 1, 32'd65535};

        // Basic tagging, back-to-back, including an out-of-range flow index.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            send(tbl[i].flow, tbl[i].len, tbl[i].val, tbl[i].rdy, tbl[i].rank);
        end
        tick();

        // Weighted flow with virtual time; vt is monotone and same-cycle accept sees old vt.
        do_reset();
        cfg_we = 1'b1; cfg_flow = 4'd2; cfg_shift = 4'd2;
        tick();
        cfg_we = 1'b0;
        vt_update = 1'b1; vt_rank = 32'd1000;
        tick();
        vt_update = 1'b0;
        send(2, 10, 32'hB0, 1, 32'd1000);
        send(2, 1,  32'hB1, 1, 32'd1040);
        vt_update = 1'b1; vt_rank = 32'd500;
        tick();
        vt_update = 1'b0;
        send(3, 0, 32'hB2, 1, 32'd1000);
        vt_update = 1'b1; vt_rank = 32'd2000;
        send(4, 0, 32'hB3, 1, 32'd1000);
        vt_update = 1'b0;
        send(4, 0, 32'hB4, 1, 32'd2000);
        tick();

        // Occupancy limit, pop alongside a blocked retry, and accept+pop together.
        do_reset();
        for (int i = 0; i < 4; i++) send(1, 10, 32'h100 + i, 1, 32'(10 * i));
        send(1, 10, 32'h104, 0, 32'd0);
        pop_on(1);
        send(1, 10, 32'h105, 0, 32'd0);
        pop_off();
        send(1, 10, 32'h106, 1, 32'd40);
        send(1, 10, 32'h107, 0, 32'd0);
        pop_on(1);
        tick();
        pop_off();
        pop_on(1);
        send(1, 10, 32'h108, 1, 32'd50);
        pop_off();
        send(1, 10, 32'h109, 1, 32'd60);
        send(1, 10, 32'h10A, 0, 32'd0);
        chk("err_after_legal_pops", 32'(err), 32'd0);

        // Underflow is sticky and leaves the count at zero; vt never moves backwards.
        do_reset();
        pop_on(3);
        tick();
        pop_off();
        chk("err_underflow", 32'(err), 32'd1);
        tick();
        tick();
        chk("err_sticky", 32'(err), 32'd1);
        for (int i = 0; i < 4; i++) send(3, 5, 32'h300 + i, 1, 32'(5 * i));
        send(3, 5, 32'h304, 0, 32'd0);
        vt_update = 1'b1; vt_rank = 32'd9;
        tick();
        vt_rank = 32'd5;
        tick();
        vt_update = 1'b0;
        send(6, 0, 32'h306, 1, 32'd9);

        // Non-one-hot pop flags an error and changes no count.
        do_reset();
        for (int i = 0; i < 4; i++) send(0, 1, 32'h400 + i, 1, 32'(i));
        pop = 1'b1; pop_flow = 10'b00_0000_0011;
        tick();
        pop_off();
        chk("err_illegal_pop", 32'(err), 32'd1);
        send(0, 1, 32'h404, 0, 32'd0);

        // Shift written in the same cycle as an accept; large weights and tag wrap.
        do_reset();
        cfg_we = 1'b1; cfg_flow = 4'd0; cfg_shift = 4'd1;
        send(0, 8, 32'h500, 1, 32'd0);
        cfg_we = 1'b0;
        send(0, 8, 32'h501, 1, 32'd8);
        send(0, 0, 32'h502, 1, 32'd24);
        cfg_we = 1'b1; cfg_flow = 4'd8; cfg_shift = 4'd15;
        tick();
        cfg_we = 1'b0;
        send(8, 65535, 32'h503, 1, 32'h0000_0000);
        send(8, 65535, 32'h504, 1, 32'h7FFF_8000);
        send(8, 65535, 32'h505, 1, 32'hFFFF_0000);
        send(8, 0,     32'h506, 1, 32'h7FFE_8000);
        tick();

        // Reset right after an accept clears everything, including shift and vt.
        do_reset();
        cfg_we = 1'b1; cfg_flow = 4'd2; cfg_shift = 4'd3;
        tick();
        cfg_we = 1'b0;
        vt_update = 1'b1; vt_rank = 32'd100;
        tick();
        vt_update = 1'b0;
        send(2, 1, 32'h600, 1, 32'd100);
        rst = 1'b1;
        in_valid = 1'b1; in_flow = 4'd0;
        #1;
        chk("ready_in_rst", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        do_reset();
        send(2, 1, 32'h601, 1, 32'd0);
        send(2, 1, 32'h602, 1, 32'd1);
        send(5, 0, 32'h603, 1, 32'd0);
        chk("err_after_rst", 32'(err), 32'd0);

        tick();
        tick();
        tick();
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
